debug_write_controller: RTL and testbench
=========================================

# debug_write_controller

Front-panel debug writer for the Basys3 wrapper. It lets an operator deposit values into the register file, data memory or instruction memory using switches and two push-buttons while the CPU is halted under debug. It is the write-side counterpart of the existing switch/7-seg debug read path and issues requests on a single req/ack debug write port that the CPU top muxes into the selected memory.

## Interface
- DATA_W, 8, data-memory and register word width
- D_ADDR_W, 12, data-memory address width
- INST_W, 16, instruction width
- I_ADDR_W, 12, instruction-memory address width
- DEBOUNCE_CYCLES, 65536, number of consecutive stable synchronized samples that qualify a button level; legal range ≥2
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sw  in  16  raw board switches (asynchronous)
- btn_addr  in  1  raw button; latches address and target
- btn_write  in  1  raw button; commits data
- debug_enable  in  1  already synchronized; writes are permitted only when it is high
- wr_req  out  1  write request, held until acknowledged
- wr_target  out  2  00/01 = register, 10 = imem, 11 = dmem
- wr_addr  out  12  write address; registers use [3:0]
- wr_data  out  16  write data; [15:8] are zero for reg/dmem
- wr_ack  in  1  one-cycle acknowledge from the memory mux
- status  out  2  current state encoding, routed to LEDs
- write_count  out  8  completed writes since reset, wraps 255→0

## Operation
- sw and both buttons pass through 2-flop synchronizers, then through the debouncer, then a rising-edge detector that produces a 1-cycle pulse per press.
- State machine: IDLE(00), ARMED(01), IMEM_HI(10), REQ(11).
- IDLE: on an addr pulse with debug_enable high, latch addr=sw[11:0] and target=sw[14:13], then go to ARMED. Write pulses are ignored.
- ARMED:
  - Addr pulse re-latches addr and target, and the state stays ARMED.
  - Write pulse with target reg/dmem sets data={8'h00, sw[7:0]} and goes to REQ.
  - Write pulse with target imem captures lo=sw[7:0] and goes to IMEM_HI.
- IMEM_HI: a write pulse sets data={sw[7:0], lo} and goes to REQ. An addr pulse discards lo, re-latches addr and target, and goes to ARMED.
- REQ: wr_req=1, with wr_target, wr_addr and wr_data stable. When wr_ack is high, write_count increments and the state returns to ARMED. Button pulses are ignored while in REQ.
- debug_enable low in any state forces IDLE next cycle and drops wr_req. A pending request is abandoned and not counted.
- If an addr pulse and a write pulse occur in the same cycle, addr takes priority and the write is dropped.

## Timing
- Reset values: wr_req=0, wr_target=0, wr_addr=0, wr_data=0, status=00, write_count=0, debouncer outputs=0, state=IDLE.
- A button press reaches the edge pulse after 2 sync cycles plus DEBOUNCE_CYCLES stable cycles. A bounce restarts the count.
- The cycle after a write pulse, the FSM is in REQ and wr_req=1.
- wr_ack is sampled only while wr_req=1. Ack in the first REQ cycle is legal, giving a minimum request width of 1 cycle.
- wr_req deasserts in the cycle after the ack.
- wr_ack while not in REQ is ignored.
- Reset asserted mid-request clears everything within one cycle, with no write counted.

## Configuration
- DEBUG_WRITE_AUTOINC_EN defined: on each acknowledged write, wr_addr increments by 1 and wraps modulo 2^D_ADDR_W for dmem, 2^I_ADDR_W for imem and 16 for registers. Consecutive write presses therefore fill sequential locations.
- Undefined: wr_addr holds the latched value until the next addr pulse.

## Structure
- Shared package debug_pkg:
  - target enum: TGT_REG=2'b00, TGT_IMEM=2'b10, TGT_DMEM=2'b11.
  - FSM state enum, whose encoding matches status.
- Sub-module button_debouncer, instantiated twice. It contains the 2-flop sync, the stable counter with parameter DEBOUNCE_CYCLES, and the registered level plus rising-edge pulse outputs.

## Test plan
Benches use DEBOUNCE_CYCLES=4.
- Dmem write:
  - Stimulus: debug_enable=1; sw=0x6123, press addr; sw=0x00A5, press write; ack 2 cycles after wr_req rises.
  - Response: wr_target=11, wr_addr=0x123, wr_data=0x00A5, and wr_req high exactly until the cycle after ack. write_count=1.
- Imem two-phase write:
  - Stimulus: sw=0x4010, press addr; press write with sw[7:0]=0x34, then with 0x12; immediate ack.
  - Response: exactly one request with wr_target=10, wr_addr=0x010, wr_data=0x1234.
- Bounce rejection: press glitching high 3 cycles, low 1 cycle, then high for 6 cycles → exactly one edge pulse.
- Abort: debug_enable drops while in REQ without ack → wr_req=0 and status=00 the next cycle; write_count unchanged.
- Auto-increment (with DEBUG_WRITE_AUTOINC_EN): register target with addr 0xF, two acknowledged writes → wr_addr is 0xF for the first write and 0x0 for the second. Without the macro, both writes use 0xF.
- Reset mid-request and counter wrap:
  - Reset asserted in REQ → all outputs return to their reset values.
  - 256 acknowledged writes → write_count=0.

Source files
------------

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared types for the front-panel debug write path.
//   target_e : memory selected by a debug write (wr_target encoding)
//   state_e  : debug_write_controller FSM state, encoding equals the status LEDs
//   decode_target() : folds the raw 2-bit switch selector onto target_e
// -----------------------------------------------------------------------------
package debug_pkg;

    localparam int WR_ADDR_W = 12;
    localparam int WR_DATA_W = 16;

    typedef enum logic [1:0] {
        TGT_REG  = 2'b00,
        TGT_IMEM = 2'b10,
        TGT_DMEM = 2'b11
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_IMEM_HI = 2'b10,
        ST_REQ     = 2'b11
    } state_e;

    // Selector 01 is an alias for the register file.
    function automatic target_e decode_target(input logic [1:0] sel);
        case (sel)
            2'b10:   return TGT_IMEM;
            2'b11:   return TGT_DMEM;
            default: return TGT_REG;
        endcase
    endfunction

endpackage

// File: rtl/debug_write_controller_if.sv
// -----------------------------------------------------------------------------
// debug_write_controller_if
// Single req/ack debug write port between the front-panel writer and the CPU
// top's memory mux.
//   wr_req    : request, held until acknowledged
//   wr_target : target_e memory select
//   wr_addr   : write address (registers use [3:0])
//   wr_data   : write data
//   wr_ack    : one-cycle acknowledge from the memory mux
// Modports: master = debug writer, slave = memory mux.
// -----------------------------------------------------------------------------
interface debug_write_controller_if;
    import debug_pkg::*;

    logic                 wr_req;
    target_e              wr_target;
    logic [WR_ADDR_W-1:0] wr_addr;
    logic [WR_DATA_W-1:0] wr_data;
    logic                 wr_ack;

    modport master (
        output wr_req, wr_target, wr_addr, wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req, wr_target, wr_addr, wr_data,
        output wr_ack
    );

endinterface

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Cleans one raw push-button: 2-flop synchronizer, stable-sample counter,
// registered debounced level and a one-cycle rising-edge pulse.
//   clk       in  system clock
//   reset_n   in  synchronous, active-low reset
//   btn_i     in  raw asynchronous button
//   level_o   out debounced level
//   pulse_o   out one-cycle pulse when level_o rises
// Parameter DEBOUNCE_CYCLES (>=2): consecutive synchronized samples that must
// disagree with the current level before the level flips.
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        // Counting only runs while the sample disagrees with the level; one
        // agreeing sample (a bounce) drops the count back to zero.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
                pulse_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/debug_write_controller.sv
// -----------------------------------------------------------------------------
// debug_write_controller
// Front-panel debug writer: the operator deposits values into the register
// file, data memory or instruction memory with switches and two buttons while
// the CPU is halted under debug.
//   clk             in  system clock
//   reset_n         in  synchronous, active-low reset
//   sw_i[15:0]      in  raw switches: [11:0] address, [14:13] target, [7:0] data
//   btn_addr_i      in  raw button, latches address and target
//   btn_write_i     in  raw button, commits data
//   debug_enable_i  in  synchronized debug enable; low forces IDLE
//   wr_if           master side of the req/ack debug write port
//   status_o[1:0]   out FSM state (IDLE 00, ARMED 01, IMEM_HI 10, REQ 11)
//   write_count_o   out acknowledged writes since reset, wraps at 256
// Build option: define DEBUG_WRITE_AUTOINC_EN to advance wr_addr after every
// acknowledged write (wrapping per target address width).
// -----------------------------------------------------------------------------
module debug_write_controller
    import debug_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int D_ADDR_W        = 12,
    parameter int INST_W          = 16,
    parameter int I_ADDR_W        = 12,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [15:0]                     sw_i,
    input  logic                            btn_addr_i,
    input  logic                            btn_write_i,
    input  logic                            debug_enable_i,
    debug_write_controller_if.master        wr_if,
    output logic [1:0]                      status_o,
    output logic [7:0]                      write_count_o
);

`ifdef DEBUG_WRITE_AUTOINC_EN
    localparam bit AUTOINC_EN = 1'b1;
`else
    localparam bit AUTOINC_EN = 1'b0;
`endif

    localparam logic [WR_ADDR_W-1:0] DMEM_MASK = WR_ADDR_W'((64'd1 << D_ADDR_W) - 64'd1);
    localparam logic [WR_ADDR_W-1:0] IMEM_MASK = WR_ADDR_W'((64'd1 << I_ADDR_W) - 64'd1);
    localparam logic [WR_ADDR_W-1:0] REG_MASK  = WR_ADDR_W'(4'hF);

    logic [15:0]          sw_meta_q, sw_q;
    logic                 addr_pulse, write_pulse;
    logic                 unused_addr_level, unused_write_level, unused_sw;

    state_e               state_q, state_d;
    target_e              target_q, target_d;
    logic [WR_ADDR_W-1:0] addr_q, addr_d;
    logic [WR_DATA_W-1:0] data_q, data_d;
    logic [7:0]           lo_q, lo_d;
    logic [7:0]           count_q, count_d;
    logic [WR_ADDR_W-1:0] addr_mask, addr_inc;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_addr_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_addr_i),
        .level_o (unused_addr_level),
        .pulse_o (addr_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_write_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (btn_write_i),
        .level_o (unused_write_level),
        .pulse_o (write_pulse)
    );

    // Switches are slow-moving; a plain 2-flop synchronizer is enough since a
    // switch settles long before the debounced button that consumes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_q      <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_q      <= sw_meta_q;
        end
    end

    assign unused_sw = ^{sw_q[15], sw_q[12]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= TGT_REG;
            addr_q   <= '0;
            data_q   <= '0;
            lo_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            lo_q     <= lo_d;
            count_q  <= count_d;
        end
    end

    // Auto-increment wraps within the address space of the selected memory.
    always_comb begin
        case (target_q)
            TGT_IMEM: addr_mask = IMEM_MASK;
            TGT_DMEM: addr_mask = DMEM_MASK;
            default:  addr_mask = REG_MASK;
        endcase
        addr_inc = (addr_q + WR_ADDR_W'(1)) & addr_mask;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        addr_d   = addr_q;
        data_d   = data_q;
        lo_d     = lo_q;
        count_d  = count_q;

        if (!debug_enable_i) begin
            // Leaving debug abandons any pending request without counting it.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (addr_pulse) begin
                        addr_d   = sw_q[WR_ADDR_W-1:0];
                        target_d = decode_target(sw_q[14:13]);
                        state_d  = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Address has priority: a simultaneous write is dropped.
                    if (addr_pulse) begin
                        addr_d   = sw_q[WR_ADDR_W-1:0];
                        target_d = decode_target(sw_q[14:13]);
                    end else if (write_pulse) begin
                        if (target_q == TGT_IMEM) begin
                            lo_d    = sw_q[7:0];
                            state_d = ST_IMEM_HI;
                        end else begin
                            data_d  = WR_DATA_W'(sw_q[DATA_W-1:0]);
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_IMEM_HI: begin
                    if (addr_pulse) begin
                        addr_d   = sw_q[WR_ADDR_W-1:0];
                        target_d = decode_target(sw_q[14:13]);
                        lo_d     = '0;
                        state_d  = ST_ARMED;
                    end else if (write_pulse) begin
                        data_d  = WR_DATA_W'(INST_W'({sw_q[7:0], lo_q}));
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wr_if.wr_ack) begin
                        count_d = count_q + 8'd1;
                        state_d = ST_ARMED;
                        if (AUTOINC_EN) begin
                            addr_d = addr_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wr_if.wr_req    = (state_q == ST_REQ);
    assign wr_if.wr_target = target_q;
    assign wr_if.wr_addr   = addr_q;
    assign wr_if.wr_data   = data_q;
    assign status_o        = state_q;
    assign write_count_o   = count_q;

endmodule

// File: tb/tb_debug_write_controller.sv
// -----------------------------------------------------------------------------
// tb_debug_write_controller
// Directed bench for debug_write_controller with DEBOUNCE_CYCLES=4. Expected
// write requests are queued as stimulus is issued; a negedge monitor pops one
// per rising wr_req and compares target/address/data.
// -----------------------------------------------------------------------------
module tb_debug_write_controller;
    import debug_pkg::*;

    typedef struct {
        logic [1:0]  tgt;
        logic [11:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] sw;
    logic        btn_addr;
    logic        btn_write;
    logic        debug_enable;
    logic [1:0]  status;
    logic [7:0]  write_count;

    debug_write_controller_if bus ();

    debug_write_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sw_i           (sw),
        .btn_addr_i     (btn_addr),
        .btn_write_i    (btn_write),
        .debug_enable_i (debug_enable),
        .wr_if          (bus),
        .status_o       (status),
        .write_count_o  (write_count)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   wpulse_cnt = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic prev_req = 1'b0;
    logic [1:0]  exp_tgt;
    logic [11:0] exp_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] next_addr(input logic [1:0] t, input logic [11:0] a);
`ifdef DEBUG_WRITE_AUTOINC_EN
        logic [3:0] r;
        r = a[3:0] + 4'd1;
        if (t == 2'b10 || t == 2'b11) return a + 12'd1;
        return {8'h00, r};
`else
        if (t == 2'b11) return a;
        return a;
`endif
    endfunction

    // Scoreboard monitor: one expected entry per request, fields held stable.
    always @(negedge clk) begin
        if (bus.wr_req && !prev_req) begin
            check("req_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("req_target", 32'(bus.wr_target), 32'(cur.tgt));
                check("req_addr", 32'(bus.wr_addr), 32'(cur.addr));
                check("req_data", 32'(bus.wr_data), 32'(cur.data));
            end
        end else if (bus.wr_req) begin
            check("req_stable", {bus.wr_target, bus.wr_addr, bus.wr_data}, {cur.tgt, cur.addr, cur.data});
        end
        prev_req = bus.wr_req;
    end

    always @(negedge clk) begin
        if (dut.u_write_db.pulse_o) wpulse_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic a, input logic w, input logic [15:0] s);
        sw = s;
        tick(3);
        btn_addr  = a;
        btn_write = w;
        tick(10);
        btn_addr  = 1'b0;
        btn_write = 1'b0;
        tick(10);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 100; i++) begin
            if (bus.wr_req) break;
            tick(1);
        end
        check("req_seen", 32'(bus.wr_req), 32'd1);
    endtask

    // Write press that is acknowledged 'delay' cycles after wr_req rises.
    task automatic write_req(input logic [15:0] s, input int delay);
        sw = s;
        tick(3);
        btn_write = 1'b1;
        wait_req();
        for (int i = 0; i < delay; i++) begin
            tick(1);
            check("req_held", 32'(bus.wr_req), 32'd1);
        end
        bus.wr_ack = 1'b1;
        tick(1);
        bus.wr_ack = 1'b0;
        check("req_drop_after_ack", 32'(bus.wr_req), 32'd0);
        check("status_after_ack", 32'(status), 32'd1);
        btn_write = 1'b0;
        tick(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(bus.wr_req), 32'd0);
        check({tag, "_target"}, 32'(bus.wr_target), 32'd0);
        check({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_count"}, 32'(write_count), 32'd0);
    endtask

    initial begin
        int p0;
        reset_n      = 1'b0;
        sw           = '0;
        btn_addr     = 1'b0;
        btn_write    = 1'b0;
        debug_enable = 1'b0;
        bus.wr_ack   = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        check_reset_outputs("reset");
        check("reset_db_level", 32'(dut.u_addr_db.level_o), 32'd0);
        debug_enable = 1'b1;

        // Dmem write, ack two cycles after the request rises.
        press(1'b1, 1'b0, 16'h6123);
        exp_tgt = 2'b11; exp_addr = 12'h123;
        check("armed_status", 32'(status), 32'd1);
        exp_q.push_back('{exp_tgt, exp_addr, 16'h00A5});
        write_req(16'h00A5, 2);
        exp_addr = next_addr(exp_tgt, exp_addr);
        check("dmem_count", 32'(write_count), 32'd1);

        // Ack outside REQ has no effect.
        bus.wr_ack = 1'b1;
        tick(1);
        bus.wr_ack = 1'b0;
        tick(1);
        check("stray_ack_count", 32'(write_count), 32'd1);
        check("stray_ack_status", 32'(status), 32'd1);

        // Imem two-phase write with immediate ack.
        press(1'b1, 1'b0, 16'h4010);
        exp_tgt = 2'b10; exp_addr = 12'h010;
        press(1'b0, 1'b1, 16'h0034);
        check("imem_hi_status", 32'(status), 32'd2);
        exp_q.push_back('{exp_tgt, exp_addr, 16'h1234});
        write_req(16'h0012, 0);
        exp_addr = next_addr(exp_tgt, exp_addr);
        check("imem_count", 32'(write_count), 32'd2);

        // Bounce: high 3, low 1, high 6 -> exactly one pulse.
        sw = 16'h0056;
        tick(3);
        p0 = wpulse_cnt;
        btn_write = 1'b1; tick(3);
        btn_write = 1'b0; tick(1);
        btn_write = 1'b1; tick(6);
        btn_write = 1'b0; tick(10);
        check("bounce_pulses", 32'(wpulse_cnt - p0), 32'd1);
        check("bounce_status", 32'(status), 32'd2);

        // Simultaneous addr+write from IMEM_HI: addr wins, write dropped.
        p0 = wpulse_cnt;
        press(1'b1, 1'b1, 16'h6200);
        exp_tgt = 2'b11; exp_addr = 12'h200;
        check("prio_write_pulse_seen", 32'(wpulse_cnt - p0), 32'd1);
        check("prio_status", 32'(status), 32'd1);
        check("prio_addr", 32'(bus.wr_addr), 32'h200);
        check("prio_target", 32'(bus.wr_target), 32'd3);

        // Abort: debug_enable drops while the request is pending.
        exp_q.push_back('{exp_tgt, exp_addr, 16'h0077});
        sw = 16'h0077;
        tick(3);
        btn_write = 1'b1;
        wait_req();
        debug_enable = 1'b0;
        tick(1);
        check("abort_req", 32'(bus.wr_req), 32'd0);
        check("abort_status", 32'(status), 32'd0);
        check("abort_count", 32'(write_count), 32'd2);
        btn_write = 1'b0;
        tick(10);
        debug_enable = 1'b1;

        // Write press in IDLE is ignored.
        press(1'b0, 1'b1, 16'h00EE);
        check("idle_write_status", 32'(status), 32'd0);
        check("idle_write_req", 32'(bus.wr_req), 32'd0);

        // Register target at 0xF, two writes (auto-increment wraps to 0).
        press(1'b1, 1'b0, 16'h000F);
        exp_tgt = 2'b00; exp_addr = 12'h00F;
        exp_q.push_back('{exp_tgt, exp_addr, 16'h0011});
        write_req(16'h0011, 0);
        exp_addr = next_addr(exp_tgt, exp_addr);
        exp_q.push_back('{exp_tgt, exp_addr, 16'h0022});
        write_req(16'h0022, 1);
        exp_addr = next_addr(exp_tgt, exp_addr);
        check("reg_count", 32'(write_count), 32'd4);
`ifdef DEBUG_WRITE_AUTOINC_EN
        check("reg_addr_after", 32'(bus.wr_addr), 32'h001);
`else
        check("reg_addr_after", 32'(bus.wr_addr), 32'h00F);
`endif

        // Reset in the middle of a request.
        exp_q.push_back('{exp_tgt, exp_addr, 16'h0033});
        sw = 16'h0033;
        tick(3);
        btn_write = 1'b1;
        wait_req();
        reset_n = 1'b0;
        tick(1);
        check_reset_outputs("midreq_reset");
        btn_write = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // 256 acknowledged writes wrap the counter back to zero.
        press(1'b1, 1'b0, 16'h6000);
        exp_tgt = 2'b11; exp_addr = 12'h000;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{exp_tgt, exp_addr, {8'h00, 8'(i)}});
            write_req({8'h00, 8'(i)}, 0);
            exp_addr = next_addr(exp_tgt, exp_addr);
            if (i == 254) check("count_255", 32'(write_count), 32'd255);
        end
        check("count_wrap", 32'(write_count), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
